// File: rtl/contador_mmss_param_pkg.sv
// Shared types and constants for the parametrised mm:ss countdown timer.
package contador_mmss_param_pkg;

    localparam int unsigned DIG_W         = 4;
    localparam int unsigned DIG_MAX_UNITS = 9;
    localparam int unsigned DIG_MAX_TENS  = 5;

    typedef enum logic [1:0] {
        ST_SET   = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // Datapath operation selected by the priority decoder for this cycle.
    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_CLEAR = 3'd1,
        OP_SHIFT = 3'd2,
        OP_NORM  = 3'd3,
        OP_ADD   = 3'd4,
        OP_DEC   = 3'd5
    } op_t;

endpackage

// File: rtl/contador_mmss_param_if.sv
// Keypad/control strobes in, BCD count and status out.
interface contador_mmss_param_if
    import contador_mmss_param_pkg::*;
#(
    parameter int unsigned MIN_DIGITS = 2
);
    localparam int unsigned NDIG = MIN_DIGITS + 2;

    logic [DIG_W-1:0]      data;
    logic                  key_valid;
    logic                  start;
    logic                  stop;
    logic                  add;
    logic                  tick;
    logic [DIG_W*NDIG-1:0] count;
    logic                  running;
    logic                  paused;
    logic                  zero;
    logic                  done;

    modport master (
        output data, key_valid, start, stop, add, tick,
        input  count, running, paused, zero, done
    );

    modport slave (
        input  data, key_valid, start, stop, add, tick,
        output count, running, paused, zero, done
    );

endinterface

// File: rtl/contador_mmss_param_bcd_digit_cell.sv
// One BCD digit register with load, borrow-chained decrement and carry-chained add.
module bcd_digit_cell
    import contador_mmss_param_pkg::*;
#(
    parameter int unsigned MODMAX = DIG_MAX_UNITS
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [DIG_W-1:0] wr_val,
    input  logic             dec_en,
    input  logic             bin,
    output logic             bout,
    input  logic             add_en,
    input  logic [DIG_W-1:0] addend,
    input  logic             cin,
    output logic             cout,
    output logic [DIG_W-1:0] q
);
    localparam int unsigned SUM_W = DIG_W + 1;

    logic [SUM_W-1:0] sum;
    logic [DIG_W-1:0] add_val;
    logic [DIG_W-1:0] dec_val;

    // Add/decrement results and chain outputs, independent of the enables.
    always_comb begin
        sum     = SUM_W'(q) + SUM_W'(addend) + SUM_W'(cin);
        cout    = (sum > SUM_W'(MODMAX));
        add_val = cout ? DIG_W'(sum - SUM_W'(MODMAX + 1)) : DIG_W'(sum);
        bout    = bin && (q == '0);
        dec_val = (q == '0) ? DIG_W'(MODMAX) : q - DIG_W'(1);
    end

    // Digit register; a direct load overrides arithmetic.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            q <= '0;
        end else if (wr_en) begin
            q <= wr_val;
        end else if (add_en) begin
            q <= add_val;
        end else if (dec_en && bin) begin
            q <= dec_val;
        end
    end

endmodule

// File: rtl/contador_mmss_param.sv
// Microwave mm:ss countdown timer: keypad entry, start/pause/cancel, +N s quick key.
module contador_mmss_param
    import contador_mmss_param_pkg::*;
#(
    parameter int unsigned MIN_DIGITS  = 2,
    parameter int unsigned ADD_SECONDS = 30
) (
    input  logic clk,
    input  logic clear,
    contador_mmss_param_if.slave bus
);
    localparam int unsigned NDIG  = MIN_DIGITS + 2;
    localparam int unsigned CNT_W = DIG_W * NDIG;
    localparam logic [DIG_W-1:0] ADD_TENS = DIG_W'(ADD_SECONDS / 10);

    state_t state, state_next;
    op_t    op;
    logic   with_add;
    logic   done_next;
    logic   running_q, paused_q, done_q;

    logic [DIG_W-1:0] q       [NDIG];
    logic [DIG_W-1:0] wr_val  [NDIG];
    logic [DIG_W-1:0] addend  [NDIG];
    logic [NDIG-1:0]  wr_en;
    logic [NDIG-1:0]  add_en;
    logic [NDIG-1:0]  bin;
    logic [NDIG-1:0]  bout;
    logic [NDIG-1:0]  cin;
    logic [NDIG-1:0]  cout;
    logic             dec_en;
    logic [CNT_W-1:0] count_w;
    logic             zero_c;
    logic [DIG_W:0]   tens_sum;
    logic [1:0]       norm_carry;
    logic [DIG_W-1:0] tens_norm;
    logic             sat;

    // Digit cells: [0] seconds units, [1] seconds tens, [2..] minutes.
    for (genvar i = 0; i < NDIG; i++) begin : g_dig
        localparam int unsigned MM = (i == 1) ? DIG_MAX_TENS : DIG_MAX_UNITS;

        bcd_digit_cell #(.MODMAX(MM)) u_cell (
            .clk    (clk),
            .clear  (clear),
            .wr_en  (wr_en[i]),
            .wr_val (wr_val[i]),
            .dec_en (dec_en),
            .bin    (bin[i]),
            .bout   (bout[i]),
            .add_en (add_en[i]),
            .addend (addend[i]),
            .cin    (cin[i]),
            .cout   (cout[i]),
            .q      (q[i])
        );

        assign count_w[i*DIG_W +: DIG_W] = q[i];

        if (i == 0) begin : g_lsd
            assign bin[i] = 1'b1;
            assign cin[i] = 1'b0;
        end else if (i == 2) begin : g_min_lsd
            // In SET the tens carry comes from normalisation, not from the tens cell.
            assign bin[i] = bout[i-1];
            assign cin[i] = (op == OP_ADD) && cout[i-1];
        end else begin : g_mid
            assign bin[i] = bout[i-1];
            assign cin[i] = cout[i-1];
        end
    end

    assign zero_c      = (count_w == '0);
    assign bus.count   = count_w;
    assign bus.zero    = zero_c;
    assign bus.running = running_q;
    assign bus.paused  = paused_q;
    assign bus.done    = done_q;

    // Next state and per-cycle operation; stop > start > add > tick > key_valid.
    always_comb begin
        state_next = state;
        op         = OP_NONE;
        with_add   = 1'b0;
        done_next  = 1'b0;
        case (state)
            ST_SET: begin
                if (bus.stop) begin
                    op = OP_CLEAR;
                end else if (bus.start) begin
                    if (!zero_c) begin
                        op         = OP_NORM;
                        state_next = ST_RUN;
                    end
                end else if (bus.add) begin
                    op         = OP_NORM;
                    with_add   = 1'b1;
                    state_next = ST_RUN;
                end else if (bus.key_valid && (bus.data <= DIG_W'(DIG_MAX_UNITS))) begin
                    op = OP_SHIFT;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    state_next = ST_PAUSE;
                end else if (bus.add) begin
                    op = OP_ADD;
                end else if (bus.tick) begin
                    op = OP_DEC;
                    if (count_w == CNT_W'(1)) begin
                        state_next = ST_SET;
                        done_next  = 1'b1;
                    end
                end
            end
            ST_PAUSE: begin
                if (bus.stop) begin
                    op         = OP_CLEAR;
                    state_next = ST_SET;
                end else if (bus.start) begin
                    state_next = ST_RUN;
                end else if (bus.add) begin
                    op = OP_ADD;
                end
            end
            default: begin
                state_next = ST_SET;
            end
        endcase
    end

    // Arithmetic enables: normalise (+quick add) in SET, quick add, or decrement.
    always_comb begin
        add_en = '0;
        dec_en = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            addend[i] = '0;
        end
        tens_sum = (DIG_W+1)'(q[1]) + (with_add ? (DIG_W+1)'(ADD_TENS) : '0);
        if (tens_sum >= (DIG_W+1)'(12)) begin
            norm_carry = 2'd2;
            tens_norm  = DIG_W'(tens_sum - (DIG_W+1)'(12));
        end else if (tens_sum >= (DIG_W+1)'(6)) begin
            norm_carry = 2'd1;
            tens_norm  = DIG_W'(tens_sum - (DIG_W+1)'(6));
        end else begin
            norm_carry = 2'd0;
            tens_norm  = DIG_W'(tens_sum);
        end
        case (op)
            OP_NORM: begin
                for (int i = 2; i < NDIG; i++) begin
                    add_en[i] = 1'b1;
                end
                addend[2] = DIG_W'(norm_carry);
            end
            OP_ADD: begin
                for (int i = 1; i < NDIG; i++) begin
                    add_en[i] = 1'b1;
                end
                addend[1] = ADD_TENS;
            end
            OP_DEC: begin
                // Never wrap below 00:00.
                dec_en = !bout[NDIG-1];
            end
            default: begin
            end
        endcase
    end

    // Direct digit loads: clear, keypad shift, normalised tens, or saturation.
    always_comb begin
        wr_en = '0;
        for (int i = 0; i < NDIG; i++) begin
            wr_val[i] = '0;
        end
        sat = ((op == OP_NORM) || (op == OP_ADD)) && cout[NDIG-1];
        if (sat) begin
            wr_en = '1;
            for (int i = 0; i < NDIG; i++) begin
                wr_val[i] = (i == 1) ? DIG_W'(DIG_MAX_TENS) : DIG_W'(DIG_MAX_UNITS);
            end
        end else begin
            case (op)
                OP_CLEAR: begin
                    wr_en = '1;
                end
                OP_SHIFT: begin
                    wr_en     = '1;
                    wr_val[0] = bus.data;
                    for (int i = 1; i < NDIG; i++) begin
                        wr_val[i] = q[i-1];
                    end
                end
                OP_NORM: begin
                    wr_en[1]  = 1'b1;
                    wr_val[1] = tens_norm;
                end
                default: begin
                end
            endcase
        end
    end

    // State register plus registered status outputs.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state     <= ST_SET;
            running_q <= 1'b0;
            paused_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_next;
            running_q <= (state_next == ST_RUN);
            paused_q  <= (state_next == ST_PAUSE);
            done_q    <= done_next;
        end
    end

endmodule

// File: tb/tb_contador_mmss_param.sv
// Self-checking bench for contador_mmss_param (MIN_DIGITS=2, ADD_SECONDS=30).
module tb_contador_mmss_param;

    localparam int unsigned MIN_D = 2;
    localparam int unsigned ADD_S = 30;
    localparam int          CAP   = 99 * 60 + 59;

    logic clk = 1'b0;
    logic clear;

    always #5 clk = ~clk;

    contador_mmss_param_if #(.MIN_DIGITS(MIN_D)) bus ();

    contador_mmss_param #(.MIN_DIGITS(MIN_D), .ADD_SECONDS(ADD_S)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        kv;
        logic [3:0]  d;
        logic        sta;
        logic        sto;
        logic        ad;
        logic        tk;
        logic [15:0] cnt;
        logic        run;
        logic        pau;
        logic        dn;
    } vec_t;

    vec_t vecs[$];

    // Reference model: minutes/seconds as plain integers, RUN time as total seconds.
    int mm, ss, mst;
    logic mdone;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [15:0] cnt, input logic run,
                              input logic pau, input logic dn);
        check({tag, " count"}, 32'(bus.count), 32'(cnt));
        check({tag, " running"}, 32'(bus.running), 32'(run));
        check({tag, " paused"}, 32'(bus.paused), 32'(pau));
        check({tag, " zero"}, 32'(bus.zero), 32'(cnt == 16'h0));
        check({tag, " done"}, 32'(bus.done), 32'(dn));
    endtask

    // Apply one cycle of strobes; returns 1 ns after the sampling edge.
    task automatic drive(input logic kv, input logic [3:0] d, input logic sta, input logic sto,
                         input logic ad, input logic tk);
        bus.key_valid = kv;
        bus.data      = d;
        bus.start     = sta;
        bus.stop      = sto;
        bus.add       = ad;
        bus.tick      = tk;
        @(posedge clk);
        #1;
        bus.key_valid = 1'b0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.add       = 1'b0;
        bus.tick      = 1'b0;
    endtask

    function automatic vec_t v(input logic kv, input logic [3:0] d, input logic sta,
                               input logic sto, input logic ad, input logic tk,
                               input logic [15:0] c, input logic r, input logic p, input logic dn);
        vec_t x;
        x.kv = kv; x.d = d; x.sta = sta; x.sto = sto; x.ad = ad; x.tk = tk;
        x.cnt = c; x.run = r; x.pau = p; x.dn = dn;
        return x;
    endfunction

    function automatic vec_t k(input logic [3:0] d, input logic [15:0] c);
        return v(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, c, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic model_reset();
        mm = 0; ss = 0; mst = 0; mdone = 1'b0;
    endtask

    task automatic model_set_total(input int t);
        if (t > CAP) t = CAP;
        mm = t / 60;
        ss = t % 60;
    endtask

    task automatic model_step(input logic kv, input logic [3:0] d, input logic sta,
                              input logic sto, input logic ad, input logic tk);
        int n;
        mdone = 1'b0;
        case (mst)
            0: begin
                if (sto) begin
                    mm = 0; ss = 0;
                end else if (sta) begin
                    if (mm != 0 || ss != 0) begin
                        model_set_total(mm * 60 + ss);
                        mst = 1;
                    end
                end else if (ad) begin
                    model_set_total(mm * 60 + ss + ADD_S);
                    mst = 1;
                end else if (kv && d <= 4'd9) begin
                    n  = ((mm * 100 + ss) * 10 + int'(d)) % 10000;
                    mm = n / 100;
                    ss = n % 100;
                end
            end
            1: begin
                if (sto) begin
                    mst = 2;
                end else if (ad) begin
                    model_set_total(mm * 60 + ss + ADD_S);
                end else if (tk) begin
                    n = mm * 60 + ss - 1;
                    model_set_total(n);
                    if (n == 0) begin
                        mst = 0;
                        mdone = 1'b1;
                    end
                end
            end
            default: begin
                if (sto) begin
                    mst = 0; mm = 0; ss = 0;
                end else if (sta) begin
                    mst = 1;
                end else if (ad) begin
                    model_set_total(mm * 60 + ss + ADD_S);
                end
            end
        endcase
    endtask

    function automatic logic [15:0] model_count();
        int n;
        logic [15:0] r;
        n = mm * 100 + ss;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return r;
    endfunction

    initial begin
        logic kv, sta, sto, ad, tk;
        logic [3:0] d;

        clear         = 1'b1;
        bus.key_valid = 1'b0;
        bus.data      = 4'h0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.add       = 1'b0;
        bus.tick      = 1'b0;
        #12;
        check_outs("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        clear = 1'b0;
        @(posedge clk);
        #1;

        // Keys 1,3,0; run 3 ticks; pause ignores ticks; resume.
        vecs.push_back(k(4'd1, 16'h0001));
        vecs.push_back(k(4'd3, 16'h0013));
        vecs.push_back(k(4'd0, 16'h0130));
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 16'h0130, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 1, 16'h0129, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 1, 16'h0128, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 1, 16'h0127, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 16'h0127, 0, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 1, 16'h0127, 0, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 1, 16'h0127, 0, 1, 0));
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 16'h0127, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 1, 16'h0126, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 16'h0126, 0, 1, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 0));
        // 90 s normalises to 01:30.
        vecs.push_back(k(4'd9, 16'h0009));
        vecs.push_back(k(4'd0, 16'h0090));
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 16'h0130, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 1, 16'h0129, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 16'h0129, 0, 1, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 0));
        // Minute borrows: 01:00 and 10:00.
        vecs.push_back(k(4'd1, 16'h0001));
        vecs.push_back(k(4'd0, 16'h0010));
        vecs.push_back(k(4'd0, 16'h0100));
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 16'h0100, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 1, 16'h0059, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 16'h0059, 0, 1, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(k(4'd1, 16'h0001));
        vecs.push_back(k(4'd0, 16'h0010));
        vecs.push_back(k(4'd0, 16'h0100));
        vecs.push_back(k(4'd0, 16'h1000));
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 16'h1000, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 1, 16'h0959, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 16'h0959, 0, 1, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 0));
        // Count to zero: single-cycle done, then start at zero ignored.
        vecs.push_back(k(4'd2, 16'h0002));
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 16'h0002, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 1, 16'h0001, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 1, 16'h0000, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 16'h0000, 0, 0, 0));
        // Quick add: idle, saturation, and add beating tick.
        vecs.push_back(v(0, 0, 0, 0, 1, 0, 16'h0030, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 16'h0030, 0, 1, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(k(4'd9, 16'h0009));
        vecs.push_back(k(4'd9, 16'h0099));
        vecs.push_back(k(4'd4, 16'h0994));
        vecs.push_back(k(4'd5, 16'h9945));
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 16'h9945, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, 0, 16'h9959, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 16'h9959, 0, 1, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(k(4'd1, 16'h0001));
        vecs.push_back(k(4'd0, 16'h0010));
        vecs.push_back(k(4'd0, 16'h0100));
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 16'h0100, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, 1, 16'h0130, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 16'h0130, 0, 1, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 0));
        // Non-BCD key ignored; tick does not block a key in SET.
        vecs.push_back(k(4'd1, 16'h0001));
        vecs.push_back(k(4'hA, 16'h0001));
        vecs.push_back(v(1, 2, 0, 0, 0, 1, 16'h0012, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 0));
        // Add in PAUSE, resume, stop beats start.
        vecs.push_back(k(4'd5, 16'h0005));
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 16'h0005, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 16'h0005, 0, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, 0, 16'h0035, 0, 1, 0));
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 16'h0035, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 1, 16'h0034, 1, 0, 0));
        vecs.push_back(v(0, 0, 1, 1, 0, 0, 16'h0034, 0, 1, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 0));
        // start beats add in SET; add from SET normalises first (90 s + 30 s).
        vecs.push_back(k(4'd7, 16'h0007));
        vecs.push_back(v(0, 0, 1, 0, 1, 0, 16'h0007, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 16'h0007, 0, 1, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(k(4'd9, 16'h0009));
        vecs.push_back(k(4'd0, 16'h0090));
        vecs.push_back(v(0, 0, 0, 0, 1, 0, 16'h0200, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 16'h0200, 0, 1, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].kv, vecs[i].d, vecs[i].sta, vecs[i].sto, vecs[i].ad, vecs[i].tk);
            check_outs($sformatf("vec[%0d]", i), vecs[i].cnt, vecs[i].run, vecs[i].pau, vecs[i].dn);
        end

        // Asynchronous clear while running at 05:17, visible before the next edge.
        drive(1, 4'd5, 0, 0, 0, 0);
        drive(1, 4'd1, 0, 0, 0, 0);
        drive(1, 4'd7, 0, 0, 0, 0);
        drive(0, 4'd0, 1, 0, 0, 0);
        check_outs("run517", 16'h0517, 1'b1, 1'b0, 1'b0);
        #3;
        clear = 1'b1;
        #1;
        check_outs("async_clear", 16'h0000, 1'b0, 1'b0, 1'b0);
        #1;
        clear = 1'b0;
        @(posedge clk);
        #1;
        check_outs("post_clear_idle", 16'h0000, 1'b0, 1'b0, 1'b0);
        drive(1, 4'd4, 0, 0, 0, 1);
        check_outs("post_clear_key", 16'h0004, 1'b0, 1'b0, 1'b0);
        drive(0, 4'd0, 0, 1, 0, 0);
        check_outs("post_clear_stop", 16'h0000, 1'b0, 1'b0, 1'b0);

        // Randomised traffic against the reference model.
        model_reset();
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                #2;
                clear = 1'b1;
                #1;
                model_reset();
                check_outs("rnd_clear", 16'h0000, 1'b0, 1'b0, 1'b0);
                clear = 1'b0;
            end
            kv  = ($urandom_range(0, 2) == 0);
            d   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
            sta = ($urandom_range(0, 7) == 0);
            sto = ($urandom_range(0, 39) == 0);
            ad  = ($urandom_range(0, 15) == 0);
            tk  = ($urandom_range(0, 1) == 0);
            drive(kv, d, sta, sto, ad, tk);
            model_step(kv, d, sta, sto, ad, tk);
            check_outs("rnd", model_count(), 1'(mst == 1), 1'(mst == 2), mdone);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/contador_mmss_param.md
# contador_mmss_param

Parametrised microwave countdown timer, the next generation of the level‑2 minutes/seconds counter. It holds an mm:ss BCD value with MIN_DIGITS minute digits and keypad digit entry by left shift. It adds start, pause/resume, cancel, a "+30 s" quick key with saturation, seconds normalisation, and a one‑cycle completion pulse. It sits between the keypad decoder and the display/magnetron control logic, and it is advanced by an external 1 Hz tick strobe.

## Interface
Parameters:
- MIN_DIGITS, default 2: number of minute digits (each mod 10), must be ≥1. Total digits NDIG = MIN_DIGITS+2.
- ADD_SECONDS, default 30: quick‑add amount, must be a multiple of 10 and ≤50.

Ports:
- clk, input, 1: system clock, rising edge.
- clear, input, 1: reset. One clock; reset is asynchronous and active-high.
- data, input, 4: keypad digit, BCD.
- key_valid, input, 1: one‑cycle strobe that shifts `data` in.
- start, input, 1: start/resume strobe.
- stop, input, 1: pause/cancel strobe.
- add, input, 1: quick‑add strobe.
- tick, input, 1: 1 Hz enable, one cycle wide.
- count, output, 4*NDIG: BCD digits. [3:0] is seconds units, [7:4] is seconds tens, [11:8] is minutes units, and so on upward.
- running, output, 1: state is RUN.
- paused, output, 1: state is PAUSE.
- zero, output, 1: all digits are 0 (combinational from the count registers).
- done, output, 1: one‑cycle completion pulse.

## Operation
- States: SET (reset state), RUN, PAUSE. Encoding is 2 bits.
- Input priority within one cycle: stop > start > add > tick > key_valid. Only the highest‑priority input that is valid in the current state acts; all others in that cycle are dropped.
- SET:
  - key_valid with data ≤9 shifts all digits up one position, discards the top digit, and puts data in the units position. key_valid with data >9 is ignored.
  - The seconds‑tens digit may hold 0–9 in SET.
  - start with zero=1 is ignored.
  - start with zero=0 normalises and enters RUN. Normalising: if seconds‑tens >5, subtract 6 from it and carry 1 into the minutes.
  - add enters RUN with the normalised value plus ADD_SECONDS.
  - stop clears all digits to 0.
- RUN:
  - tick decrements by 1 s. Seconds units borrow reloads 9. Seconds tens borrow reloads 5. Minute digits borrow reloads 9.
  - The tick that makes the count 0 also sets done and returns to SET.
  - stop enters PAUSE.
  - add adds ADD_SECONDS. A tick in the same cycle as add is lost.
  - key_valid is ignored.
- PAUSE:
  - start returns to RUN.
  - stop returns to SET and clears the count to 0.
  - add adds ADD_SECONDS and stays in PAUSE.
  - tick and key_valid are ignored.
- Add arithmetic: seconds tens += ADD_SECONDS/10. If the result is ≥6, subtract 6 and ripple a carry through the minute digits. A carry out of the top minute digit saturates the count to all minute digits 9 and seconds 59.
- Normalisation saturates the same way.

## Timing
- All state and count updates register on the rising clk edge of the cycle in which the strobe is sampled. New values are visible in the next cycle. There is no other latency.
- done is high for exactly one cycle: the cycle after the final tick. In that cycle count=0, zero=1, running=0.
- Values during and after clear:
  - While clear is high (asynchronous): count=0, state is SET, running=0, paused=0, done=0, zero=1.
  - A clear in mid‑RUN aborts without asserting done.
  - The first edge after clear deasserts behaves as in SET.
- Strobes held high for several cycles act once per cycle.

## Structure
- Shared package holds:
  - state encodings ST_SET, ST_RUN, ST_PAUSE;
  - digit limits DIG_MAX_UNITS=9 and DIG_MAX_TENS=5;
  - the BCD digit width constant 4.
- One sub-module, `bcd_digit_cell`:
  - parameter MODMAX (9 or 5);
  - one 4‑bit register with shift‑load, decrement with borrow‑in/borrow‑out, and add with carry‑in/carry‑out;
  - instantiated NDIG times in a generate loop.
- FSM, priority decode, normalisation and saturation live in the top module.

## Test plan
All scenarios use MIN_DIGITS=2.
1. Keys 1,3,0, then start, then 3 ticks → count 0x0127, running=1. Then stop, 2 ticks → count stays 0x0127, paused=1. Then start, 1 tick → 0x0126.
2. Keys 9,0, then start → next cycle count 0x0130, running=1. Then tick → 0x0129.
3. Keys 1,0,0, then start, then tick → 0x0059. A separate run loaded 10:00, then start, then tick → 0x0959.
4. Keys 2, then start, then 2 ticks → done=1 for exactly one cycle after the 2nd tick, with count 0x0000, zero=1, running=0. Then start is ignored (state stays SET).
5. Idle add → 0x0030 with running=1. A run loaded with 99:45, then add → 0x9959 (saturated). add and tick in the same cycle at 0x0100 → 0x0130.
6. Running at 05:17, assert clear asynchronously between edges → count 0x0000, state SET and zero=1 before the next edge. Key 0xA in SET is ignored. A stop in PAUSE clears the count to 0x0000 and returns to SET.
